fip_var_encoder: RTL and testbench

FIP_VAR_ENCODER -- requirements
Module: fip_var_encoder

---
 rtl/fip_var_encoder.sv | 169 ++++++++++++++++
 tb/tb_fip_var_encoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fip_var_encoder.sv
// fip_var_encoder: decodes a three-byte ID_DAT frame (control, variable, address)
// into a variable code and presents it to the variable decoder with a
// valid/ready handshake.
//
// Parameters:
//   TIMEOUT_CYCLES - max idle cycles between bytes of one frame before abort
//   CTRL_ID_DAT    - control byte that opens an ID_DAT frame
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   byte_i/byte_valid_i - received byte and its one-cycle strobe
//   subs_i              - own station address, compared against the third byte
//   var_o/var_valid_o   - decoded variable code and its valid flag (registered)
//   var_ready_i         - consumer accepts var_o
//   rst_req_o           - one-cycle pulse when var_rst is handed off
//   err_o               - one-cycle pulse on frame abort
// Configuration:
//   FIP_VAR_RST_EN - when defined, E0h decodes to var_rst and its handoff
//                    pulses rst_req_o; otherwise E0h is rejected as var_whatever.

// Variable code shared with the variable decoder.
typedef enum integer {
  var_presence,
  var_identif,
  var_1,
  var_2,
  var_3,
  var_rst,
  var_4,
  var_5,
  var_whatever
} t_var;

module fip_var_encoder #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  CTRL_ID_DAT    = 8'h03
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  input  logic [7:0] subs_i,
  output t_var       var_o,
  output logic       var_valid_o,
  input  logic       var_ready_i,
  output logic       rst_req_o,
  output logic       err_o
);

  typedef enum logic [1:0] {StIdle, StGetVar, StGetSubs, StPresent} state_e;

  state_e      state_q, state_d;
  t_var        var_lat_q, var_lat_d;  // code decoded from the second byte
  t_var        var_q, var_d;          // code shown on var_o
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        timeout;

  function automatic t_var map_byte(input logic [7:0] b);
    t_var v;
    case (b)
      8'h14:   v = var_presence;
      8'h10:   v = var_identif;
      8'h05:   v = var_1;
      8'h04:   v = var_2;
      8'h06:   v = var_3;
`ifdef FIP_VAR_RST_EN
      8'hE0:   v = var_rst;
`else
      8'hE0:   v = var_whatever;
`endif
      8'h91:   v = var_4;
      8'h92:   v = var_5;
      default: v = var_whatever;
    endcase
    return v;
  endfunction

  // The counter reaches TIMEOUT_CYCLES on the edge ending this cycle; a byte
  // arriving in the same cycle takes priority over the abort.
  assign timeout = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    var_lat_d = var_lat_q;
    var_d     = var_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (byte_valid_i && (byte_i == CTRL_ID_DAT)) state_d = StGetVar;
      end
      StGetVar: begin
        if (byte_valid_i) begin
          var_lat_d = map_byte(byte_i);
          state_d   = StGetSubs;
          cnt_d     = '0;
        end else if (timeout) begin
          state_d = StIdle;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StGetSubs: begin
        if (var_lat_q == var_whatever) begin
          // Unknown variables are rejected as soon as they get here.
          state_d = StIdle;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else if (byte_valid_i) begin
          cnt_d = '0;
          // Presence and identification are broadcast: any address is accepted.
          if ((var_lat_q == var_presence) || (var_lat_q == var_identif) ||
              (byte_i == subs_i)) begin
            state_d = StPresent;
            var_d   = var_lat_q;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end else if (timeout) begin
          state_d = StIdle;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StPresent: begin
        // Bytes arriving here, including one in the handoff cycle, are dropped.
        cnt_d = '0;
        if (var_ready_i) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      var_lat_q <= var_presence;
      var_q     <= var_presence;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      var_lat_q <= var_lat_d;
      var_q     <= var_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign var_o       = var_q;
  assign var_valid_o = (state_q == StPresent);
  assign err_o       = err_q;

`ifdef FIP_VAR_RST_EN
  assign rst_req_o = (state_q == StPresent) && var_ready_i && (var_q == var_rst);
`else
  assign rst_req_o = 1'b0;
`endif

endmodule

// File: tb/tb_fip_var_encoder.sv
// Self-checking bench for fip_var_encoder: table-driven frames plus directed
// sequences for backpressure, timeout, byte-vs-timeout race and reset.
module tb_fip_var_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] byte_i;
  logic       byte_valid_i;
  logic [7:0] subs_i;
  t_var       var_o;
  logic       var_valid_o;
  logic       var_ready_i;
  logic       rst_req_o;
  logic       err_o;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;

  fip_var_encoder #(
    .TIMEOUT_CYCLES(4),
    .CTRL_ID_DAT   (8'h03)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_i      (byte_i),
    .byte_valid_i(byte_valid_i),
    .subs_i      (subs_i),
    .var_o       (var_o),
    .var_valid_o (var_valid_o),
    .var_ready_i (var_ready_i),
    .rst_req_o   (rst_req_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  // err_o is a registered one-cycle pulse, so each pulse is seen on one edge.
  always @(posedge clk) if (err_o === 1'b1) err_pulses <= err_pulses + 1;

  typedef struct {
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    logic [7:0] subs;
    logic       ev;    // expect var_valid_o after the third byte
    t_var       evar;  // expected code when presented
    int         eerr;  // expected err_o pulses
    logic       erst;  // expected rst_req_o at handoff
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_i       = b;
    byte_valid_i = 1'b1;
    tick();
    byte_valid_i = 1'b0;
    byte_i       = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    t_var last;
    int   e0;

    vecs[0]  = '{8'h03, 8'h14, 8'h00, 8'h5A, 1'b1, var_presence, 0, 1'b0};
    vecs[1]  = '{8'h03, 8'h10, 8'h77, 8'h5A, 1'b1, var_identif,  0, 1'b0};
    vecs[2]  = '{8'h03, 8'h05, 8'h5A, 8'h5A, 1'b1, var_1,        0, 1'b0};
    vecs[3]  = '{8'h03, 8'h04, 8'h5A, 8'h5A, 1'b1, var_2,        0, 1'b0};
    vecs[4]  = '{8'h03, 8'h06, 8'h5B, 8'h5A, 1'b0, var_presence, 1, 1'b0};
    vecs[5]  = '{8'h03, 8'h91, 8'h5A, 8'h5A, 1'b1, var_4,        0, 1'b0};
    vecs[6]  = '{8'h03, 8'h92, 8'h5A, 8'h5A, 1'b1, var_5,        0, 1'b0};
    vecs[7]  = '{8'h03, 8'h33, 8'h5A, 8'h5A, 1'b0, var_presence, 1, 1'b0};
`ifdef FIP_VAR_RST_EN
    vecs[8]  = '{8'h03, 8'hE0, 8'h5A, 8'h5A, 1'b1, var_rst,      0, 1'b1};
`else
    vecs[8]  = '{8'h03, 8'hE0, 8'h5A, 8'h5A, 1'b0, var_presence, 1, 1'b0};
`endif
    vecs[9]  = '{8'h03, 8'h05, 8'h00, 8'h5A, 1'b0, var_presence, 1, 1'b0};
    vecs[10] = '{8'h55, 8'h05, 8'h5A, 8'h5A, 1'b0, var_presence, 0, 1'b0};

    rst_n        = 1'b0;
    byte_i       = 8'h00;
    byte_valid_i = 1'b0;
    subs_i       = 8'h5A;
    var_ready_i  = 1'b0;
    tick();
    tick();
    check("reset_var", var_o, var_presence);
    check("reset_valid", var_valid_o, 1'b0);
    check("reset_err", err_o, 1'b0);
    check("reset_rst_req", rst_req_o, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    last = var_presence;

    // Table-driven frames, consumer stalled until the code appears.
    for (int i = 0; i < 11; i++) begin
      e0          = err_pulses;
      subs_i      = vecs[i].subs;
      var_ready_i = 1'b0;
      send(vecs[i].b1);
      send(vecs[i].b2);
      send(vecs[i].b3);
      check($sformatf("v%0d_valid", i), var_valid_o, vecs[i].ev);
      if (vecs[i].ev) begin
        check($sformatf("v%0d_var", i), var_o, vecs[i].evar);
        last        = vecs[i].evar;
        var_ready_i = 1'b1;
        #1;
        check($sformatf("v%0d_rst_req", i), rst_req_o, vecs[i].erst);
        tick();
        var_ready_i = 1'b0;
        check($sformatf("v%0d_valid_drop", i), var_valid_o, 1'b0);
      end
      tick();
      tick();
      check($sformatf("v%0d_err_cnt", i), err_pulses - e0, vecs[i].eerr);
      check($sformatf("v%0d_var_hold", i), var_o, last);
    end

    // Backpressure: code held stable for 4 stalled cycles, then a CTRL byte in
    // the handoff cycle must be dropped.
    e0 = err_pulses;
    subs_i = 8'h5A;
    send(8'h03);
    send(8'h05);
    send(8'h5A);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall%0d_valid", i), var_valid_o, 1'b1);
      check($sformatf("stall%0d_var", i), var_o, var_1);
      tick();
    end
    var_ready_i  = 1'b1;
    byte_i       = 8'h03;
    byte_valid_i = 1'b1;
    #1;
    check("stall_rst_req", rst_req_o, 1'b0);
    tick();
    var_ready_i  = 1'b0;
    byte_valid_i = 1'b0;
    check("handoff_valid_drop", var_valid_o, 1'b0);
    send(8'h14);
    send(8'h00);
    tick();
    check("b2b_dropped_valid", var_valid_o, 1'b0);
    check("stall_err_cnt", err_pulses - e0, 0);

    // Timeout after 4 idle cycles in GET_VAR.
    e0 = err_pulses;
    send(8'h03);
    tick();
    tick();
    tick();
    check("to_err_early", err_o, 1'b0);
    tick();
    check("to_err_pulse", err_o, 1'b1);
    tick();
    check("to_err_single", err_o, 1'b0);
    send(8'h14);
    send(8'h00);
    tick();
    check("to_after_valid", var_valid_o, 1'b0);
    check("to_err_cnt", err_pulses - e0, 1);

    // A byte in the cycle the counter would time out wins, in both states.
    e0 = err_pulses;
    send(8'h03);
    tick();
    tick();
    tick();
    send(8'h05);
    tick();
    tick();
    tick();
    send(8'h5A);
    check("race_valid", var_valid_o, 1'b1);
    check("race_var", var_o, var_1);
    var_ready_i = 1'b1;
    tick();
    var_ready_i = 1'b0;
    tick();
    check("race_err_cnt", err_pulses - e0, 0);

    // Reset mid-frame in GET_SUBS, while the previous code is var_2.
    send(8'h03);
    send(8'h04);
    send(8'h5A);
    var_ready_i = 1'b1;
    tick();
    var_ready_i = 1'b0;
    check("pre_reset_var", var_o, var_2);
    e0 = err_pulses;
    send(8'h03);
    send(8'h05);
    #2 rst_n = 1'b0;
    #1;
    check("rst_subs_var", var_o, var_presence);
    check("rst_subs_valid", var_valid_o, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    // Reset while presenting.
    send(8'h03);
    send(8'h05);
    send(8'h5A);
    check("rst_pres_valid_pre", var_valid_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_pres_valid", var_valid_o, 1'b0);
    check("rst_pres_var", var_o, var_presence);
    #2 rst_n = 1'b1;
    tick();
    send(8'h03);
    send(8'h10);
    send(8'hC3);
    check("post_rst_valid", var_valid_o, 1'b1);
    check("post_rst_var", var_o, var_identif);
    var_ready_i = 1'b1;
    tick();
    var_ready_i = 1'b0;
    tick();
    check("rst_err_cnt", err_pulses - e0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
